// File: rtl/life_pkg.sv
// Shared types and sizing helpers for the life board and its LED scanner.
package life_pkg;

    localparam int DEF_ROWS = 16;
    localparam int DEF_COLS = 16;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, GAP} scan_state_t;

    // Width of a down-counter that holds len-1 for the longer of the two phases.
    function automatic int cnt_width(input int dwell, input int blank);
        int longest;
        longest = (dwell > blank) ? dwell : blank;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/board_scanner_scan_timer.sv
// Loadable down-counter; expired is high on the last cycle of a len-cycle interval.
module scan_timer #(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         start,
    input  logic [W:0]   len,
    output logic         expired
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_reg <= '0;
        end else if (start) begin
            cnt_reg <= W'(len - (W+1)'(1));
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign expired = (cnt_reg == '0);

endmodule

// File: rtl/board_scanner.sv
// Snapshots the life board each frame and scans it row by row onto an LED matrix.
// Optional blinking cursor overlay is built when CURSOR_BLINK_EN is defined.
module board_scanner
    import life_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int DWELL        = 2048,
    parameter int BLANK        = 4,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ROWS*COLS-1:0]  board,
    input  logic                  enable,
`ifdef CURSOR_BLINK_EN
    input  logic [$clog2(ROWS)-1:0]                 CursorRow,
    input  logic [(COLS > 1 ? $clog2(COLS) : 1)-1:0] CursorCol,
`endif
    output logic [ROWS-1:0]       RowSel,
    output logic [COLS-1:0]       ColData,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = cnt_width(DWELL, BLANK);
    localparam logic [CNT_W:0]     DWELL_LEN = (CNT_W+1)'(DWELL);
    localparam logic [CNT_W:0]     BLANK_LEN = (CNT_W+1)'(BLANK);
    localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(ROWS - 1);

    scan_state_t               state_reg, state_next;
    logic [ROW_W-1:0]          row_reg, row_next;
    logic [ROWS-1:0][COLS-1:0] snap_reg;
    logic                      timer_start;
    logic [CNT_W:0]            timer_len;
    logic                      timer_expired;
    logic                      last_gap;
    logic [COLS-1:0]           cursor_mask;

    scan_timer #(.W(CNT_W)) u_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .start   (timer_start),
        .len     (timer_len),
        .expired (timer_expired)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            snap_reg  <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            if (state_reg == LOAD) begin
                snap_reg <= board;
            end
        end
    end

    // The timer is restarted on every entry into SCAN or GAP.
    always_comb begin
        state_next  = state_reg;
        row_next    = row_reg;
        timer_start = 1'b0;
        timer_len   = DWELL_LEN;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                row_next    = '0;
                state_next  = SCAN;
                timer_start = 1'b1;
                timer_len   = DWELL_LEN;
            end
            SCAN: begin
                if (timer_expired) begin
                    state_next  = GAP;
                    timer_start = 1'b1;
                    timer_len   = BLANK_LEN;
                end
            end
            GAP: begin
                if (timer_expired) begin
                    if (row_reg != LAST_ROW) begin
                        row_next    = row_reg + ROW_W'(1);
                        state_next  = SCAN;
                        timer_start = 1'b1;
                        timer_len   = DWELL_LEN;
                    end else begin
                        state_next = enable ? LOAD : IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign last_gap    = (state_reg == GAP) && timer_expired && (row_reg == LAST_ROW);
    assign frame_done  = last_gap;
    assign frame_start = (state_reg == LOAD);
    assign busy        = (state_reg != IDLE);

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_decode
        assign RowSel[gi] = (state_reg == SCAN) && (row_reg == ROW_W'(gi));
    end

    assign ColData = (state_reg == SCAN) ? (snap_reg[row_reg] ^ cursor_mask) : '0;

`ifdef CURSOR_BLINK_EN
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FCNT_W-1:0] frame_cnt_reg;
    logic              blink_phase_reg;
    logic [ROW_W-1:0]  cur_row_reg;
    logic [COL_W-1:0]  cur_col_reg;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            cur_row_reg     <= '0;
            cur_col_reg     <= '0;
        end else begin
            if (state_reg == LOAD) begin
                cur_row_reg <= CursorRow;
                cur_col_reg <= CursorCol;
            end
            if (last_gap) begin
                if (frame_cnt_reg == FCNT_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + FCNT_W'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_cursor_decode
        assign cursor_mask[gi] = blink_phase_reg && (row_reg == cur_row_reg)
                                 && (cur_col_reg == COL_W'(gi));
    end
`else
    assign cursor_mask = '0;
`endif

endmodule

// File: tb/tb_board_scanner.sv
// Self-checking bench for board_scanner: directed table, hand sequences, random run vs frame-position model.
module tb_board_scanner;

    localparam int R    = 4;
    localparam int C    = 4;
    localparam int D    = 3;
    localparam int B    = 1;
    localparam int BF   = 2;
    localparam int FLEN = 1 + R * (D + B);

    logic          Clock = 1'b0;
    logic          Reset;
    logic [R*C-1:0] board;
    logic          enable;
    logic [R-1:0]  RowSel;
    logic [C-1:0]  ColData;
    logic          frame_start, frame_done, busy;
`ifdef CURSOR_BLINK_EN
    logic [1:0]    CursorRow, CursorCol;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    board_scanner #(.ROWS(R), .COLS(C), .DWELL(D), .BLANK(B), .BLINK_FRAMES(BF)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .board       (board),
        .enable      (enable),
`ifdef CURSOR_BLINK_EN
        .CursorRow   (CursorRow),
        .CursorCol   (CursorCol),
`endif
        .RowSel      (RowSel),
        .ColData     (ColData),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 Clock = ~Clock;

    // Reference model: position within the current frame, plus captured snapshot.
    bit        m_active = 1'b0;
    int        m_pos    = 0;
    logic [R*C-1:0] m_snap = '0;
    bit        m_blink  = 1'b0;
    int        m_fcnt   = 0;
    int        m_crow   = 0;
    int        m_ccol   = 0;

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (Reset) begin
            m_active <= 1'b0;
            m_pos    <= 0;
            m_blink  <= 1'b0;
            m_fcnt   <= 0;
        end else if (!m_active) begin
            if (enable) begin
                m_active <= 1'b1;
                m_pos    <= 0;
            end
        end else begin
            if (m_pos == 0) begin
                m_snap <= board;
`ifdef CURSOR_BLINK_EN
                m_crow <= int'(CursorRow);
                m_ccol <= int'(CursorCol);
`endif
            end
            if (m_pos == FLEN - 1) begin
                if (m_fcnt + 1 == BF) begin
                    m_fcnt  <= 0;
                    m_blink <= !m_blink;
                end else begin
                    m_fcnt <= m_fcnt + 1;
                end
                if (enable) m_pos <= 0;
                else        m_active <= 1'b0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    function automatic void expect_now(output logic [R-1:0] rs, output logic [C-1:0] cd,
                                       output logic fs, output logic fd, output logic by);
        int k, row, off;
        rs = '0; cd = '0; fs = 1'b0; fd = 1'b0; by = m_active;
        if (m_active) begin
            if (m_pos == 0) begin
                fs = 1'b1;
            end else begin
                k   = m_pos - 1;
                row = k / (D + B);
                off = k % (D + B);
                if (off < D) begin
                    rs = R'(1 << row);
                    cd = m_snap[row*C +: C];
`ifdef CURSOR_BLINK_EN
                    if (m_blink && row == m_crow) cd[m_ccol] = ~cd[m_ccol];
`endif
                end
                if (m_pos == FLEN - 1) fd = 1'b1;
            end
        end
    endfunction

    task automatic check_model(input string tag);
        logic [R-1:0] rs;
        logic [C-1:0] cd;
        logic fs, fd, by;
        expect_now(rs, cd, fs, fd, by);
        n_vec++;
        if ({RowSel, ColData, frame_start, frame_done, busy} !== {rs, cd, fs, fd, by}) begin
            n_bad++;
            $display("FAIL %s @%0d: got rs=%b cd=%h fs=%b fd=%b busy=%b, expected rs=%b cd=%h fs=%b fd=%b busy=%b",
                     tag, cyc, RowSel, ColData, frame_start, frame_done, busy, rs, cd, fs, fd, by);
        end
    endtask

    task automatic expect_val(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0d: got %h, expected %h", tag, cyc, got, want);
        end
    endtask

    task automatic step(input string tag);
        @(posedge Clock);
        @(negedge Clock);
        check_model(tag);
    endtask

    task automatic wait_rowsel(input logic [R-1:0] target, input string tag);
        int n = 0;
        while (RowSel !== target && n < 40) begin
            step(tag);
            n++;
        end
        expect_val({tag, "_reach"}, 8'(RowSel), 8'(target));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            step(tag);
            n++;
        end
        expect_val({tag, "_done"}, 8'(frame_done), 8'h01);
    endtask

    typedef struct {
        logic           rst;
        logic           en;
        logic [R*C-1:0] brd;
        logic [R-1:0]   rs;
        logic [C-1:0]   cd;
        logic           fs;
        logic           fd;
        logic           by;
    } vec_t;

    vec_t tbl[22];
    logic [C-1:0] row_val[R] = '{4'h3, 4'hC, 4'h5, 4'hA};

    initial begin
        // Directed frame: reset, release, one full frame of 16'hA5C3, start of the next.
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b1, 16'hA5C3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 16'hA5C3, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1};
        for (int r = 0; r < R; r++) begin
            for (int d = 0; d < D; d++)
                tbl[4 + r*4 + d] = '{1'b0, 1'b1, 16'hA5C3, R'(1 << r), row_val[r], 1'b0, 1'b0, 1'b1};
            tbl[4 + r*4 + 3] = '{1'b0, 1'b1, 16'hA5C3, 4'h0, 4'h0, 1'b0, (r == R-1), 1'b1};
        end
        tbl[20] = '{1'b0, 1'b1, 16'hA5C3, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 1'b1, 16'hA5C3, 4'h1, 4'h3, 1'b0, 1'b0, 1'b1};

`ifdef CURSOR_BLINK_EN
        CursorRow = 2'd0;
        CursorCol = 2'd0;
`endif
        for (int i = 0; i < 22; i++) begin
            Reset  = tbl[i].rst;
            enable = tbl[i].en;
            board  = tbl[i].brd;
            step("model_table");
            n_vec++;
            if ({RowSel, ColData, frame_start, frame_done, busy} !==
                {tbl[i].rs, tbl[i].cd, tbl[i].fs, tbl[i].fd, tbl[i].by}) begin
                n_bad++;
                $display("FAIL table[%0d]: got rs=%b cd=%h fs=%b fd=%b busy=%b, expected rs=%b cd=%h fs=%b fd=%b busy=%b",
                         i, RowSel, ColData, frame_start, frame_done, busy,
                         tbl[i].rs, tbl[i].cd, tbl[i].fs, tbl[i].fd, tbl[i].by);
            end else begin
                $display("vec %0d: rs=%b cd=%h fs=%b fd=%b busy=%b ok", i, RowSel, ColData,
                         frame_start, frame_done, busy);
            end
        end

        // Board change mid-frame must not tear the current image.
        wait_rowsel(4'b0010, "to_row1");
        board = 16'hFFFF;
        wait_rowsel(4'b0100, "old_row2");
        expect_val("old_snapshot", 8'(ColData), 8'h05);
        wait_done("old_frame");
        step("new_load");
        wait_rowsel(4'b0001, "new_row0");
        expect_val("new_snapshot_r0", 8'(ColData), 8'h0F);
        wait_rowsel(4'b1000, "new_row3");
        expect_val("new_snapshot_r3", 8'(ColData), 8'h0F);
        $display("snapshot sequence complete at cycle %0d", cyc);

        // Dropping enable mid-frame finishes the frame, then idles.
        wait_rowsel(4'b0100, "drop_row2");
        enable = 1'b0;
        wait_done("drop_frame");
        step("drop_idle");
        expect_val("idle_busy", 8'(busy), 8'h00);
        step("drop_idle2");
        expect_val("idle_stays", 8'({busy, frame_start}), 8'h00);
        $display("enable-drop sequence complete at cycle %0d", cyc);

        // Reset during row 1 goes dark on the next cycle.
        enable = 1'b1;
        wait_rowsel(4'b0010, "rst_row1");
        Reset = 1'b1;
        step("reset_mid");
        expect_val("reset_dark", 8'({RowSel, ColData}), 8'h00);
        expect_val("reset_busy", 8'(busy), 8'h00);
        Reset  = 1'b0;
        enable = 1'b0;
        step("reset_after");
        $display("mid-frame reset sequence complete at cycle %0d", cyc);

`ifdef CURSOR_BLINK_EN
        board     = '0;
        CursorRow = 2'd2;
        CursorCol = 2'd1;
        Reset     = 1'b1;
        step("cur_reset");
        Reset  = 1'b0;
        enable = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            wait_rowsel(4'b0100, "cur_row2");
            expect_val("cursor_blink", 8'(ColData), (f == 3 || f == 4) ? 8'h02 : 8'h00);
            wait_done("cur_frame");
            $display("cursor frame %0d row2=%h", f, ColData);
        end
`endif

        // Randomized run against the model.
        for (int i = 0; i < 1500; i++) begin
            board  = R*C'($urandom);
            enable = ($urandom_range(0, 7) != 0);
            Reset  = ($urandom_range(0, 299) == 0);
`ifdef CURSOR_BLINK_EN
            CursorRow = 2'($urandom);
            CursorCol = 2'($urandom);
`endif
            step("random");
            if (frame_done) $display("random frame done at cycle %0d", cyc);
        end
        Reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
